// File: rtl/hires_color_out_pkg.sv
// Shared types and constants for the hi-res colour output stage.
// Holds the boot palette and the RGB field layout.
package hires_color_out_pkg;

  localparam int CH_W  = 6;
  localparam int R_LSB = 12;
  localparam int G_LSB = 6;
  localparam int B_LSB = 0;

  localparam logic [3:0] BLACK = 4'd0;

  typedef logic [17:0] rgb_t;

  typedef struct packed {
    logic [3:0] idx;
    rgb_t       rgb;
  } pal_wr_t;

  typedef struct packed {
    rgb_t rgb;
    logic act;
    logic hs;
    logic vs;
    logic half;
  } pix_s1_t;

  // Element 0 is the rightmost entry.
  localparam rgb_t [15:0] DEFAULT_PALETTE = {
    18'h2AAAA, 18'h3F57F, 18'h15FFF, 18'h3FFD5,
    18'h1557F, 18'h15FD5, 18'h3F555, 18'h15555,
    18'h2A02A, 18'h00AAA, 18'h2AA80, 18'h0002A,
    18'h00A80, 18'h2A000, 18'h3FFFF, 18'h00000
  };

endpackage

// File: rtl/palette_wr_fifo.sv
// Pending palette-write queue.
// Valid/ready push side, pop/empty drain side.
module palette_wr_fifo
  import hires_color_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_valid,
  output logic    push_ready,
  input  pal_wr_t push_data,
  input  logic    pop,
  output logic    empty,
  output pal_wr_t pop_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  pal_wr_t       mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          do_push;
  logic          do_pop;

  // Ready comes from registered count only.
  assign push_ready = (count != DEPTH);
  assign empty      = (state == ST_EMPTY);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem[rd_ptr];

  always_comb begin
    count_nx = count;
    unique case ({do_push, do_pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
    state_nx = ST_PARTIAL;
    if (count_nx == '0) begin
      state_nx = ST_EMPTY;
    end else if (count_nx == DEPTH) begin
      state_nx = ST_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= ST_EMPTY;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hires_color_out.sv
// Palette lookup, scanline dimming and sync alignment.
// Two-stage pixel path with queued palette updates.
module hires_color_out
  import hires_color_out_pkg::*;
#(
  parameter int FIFO_DEPTH         = 4,
  parameter int SCANLINE_SHIFT     = 1,
  parameter bit COMMIT_VBLANK_ONLY = 1'b0
) (
  input  logic        clk_dot8x,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_in,
  input  logic [3:0]  pixel_color4,
  input  logic        half_bright,
  input  logic        scanline_en,
  input  logic        pal_wr_valid,
  output logic        pal_wr_ready,
  input  logic [3:0]  pal_wr_index,
  input  logic [17:0] pal_wr_rgb,
  output logic [5:0]  red,
  output logic [5:0]  green,
  output logic [5:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        active
);

  pal_wr_t   wr_data;
  pal_wr_t   pop_data;
  logic      fifo_empty;
  logic      commit;
  rgb_t      pal [16];
  pix_s1_t   s1;
  logic      dim;
  logic [5:0] r_nx;
  logic [5:0] g_nx;
  logic [5:0] b_nx;

  assign wr_data = '{idx: pal_wr_index, rgb: pal_wr_rgb};

  palette_wr_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_dot8x),
    .rst       (rst),
    .push_valid(pal_wr_valid),
    .push_ready(pal_wr_ready),
    .push_data (wr_data),
    .pop       (commit),
    .empty     (fifo_empty),
    .pop_data  (pop_data)
  );

  // Updates only land outside the visible area.
  assign commit = !fifo_empty && !active_in &&
                  (!COMMIT_VBLANK_ONLY || !vsync_in);

  always_ff @(posedge clk_dot8x) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        pal[i] <= DEFAULT_PALETTE[i];
      end
    end else if (commit) begin
      pal[pop_data.idx] <= pop_data.rgb;
    end
  end

  always_ff @(posedge clk_dot8x) begin
    if (rst) begin
      s1 <= '{rgb: '0, act: 1'b0, hs: 1'b1,
              vs: 1'b1, half: 1'b0};
    end else begin
      s1 <= '{rgb: pal[pixel_color4], act: active_in,
              hs: hsync_in, vs: vsync_in,
              half: half_bright};
    end
  end

  always_comb begin
    dim  = scanline_en && s1.half;
    r_nx = s1.rgb[R_LSB +: CH_W];
    g_nx = s1.rgb[G_LSB +: CH_W];
    b_nx = s1.rgb[B_LSB +: CH_W];
    if (dim) begin
      r_nx = r_nx >> SCANLINE_SHIFT;
      g_nx = g_nx >> SCANLINE_SHIFT;
      b_nx = b_nx >> SCANLINE_SHIFT;
    end
    if (!s1.act) begin
      r_nx = '0;
      g_nx = '0;
      b_nx = '0;
    end
  end

  always_ff @(posedge clk_dot8x) begin
    if (rst) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      active <= 1'b0;
    end else begin
      red    <= r_nx;
      green  <= g_nx;
      blue   <= b_nx;
      hsync  <= s1.hs;
      vsync  <= s1.vs;
      active <= s1.act;
    end
  end

endmodule

// File: tb/tb_hires_color_out.sv
// Bench for hires_color_out: directed vectors,
// write-queue sequences and a randomized reference model.
module tb_hires_color_out;

  logic        clk_dot8x = 1'b0;
  logic        rst;
  logic        hsync_in;
  logic        vsync_in;
  logic        active_in;
  logic [3:0]  pixel_color4;
  logic        half_bright;
  logic        scanline_en;
  logic        pal_wr_valid;
  logic        pal_wr_ready;
  logic [3:0]  pal_wr_index;
  logic [17:0] pal_wr_rgb;
  logic [5:0]  red;
  logic [5:0]  green;
  logic [5:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        active;

  int total = 0;
  int bad   = 0;

  hires_color_out dut (
    .clk_dot8x   (clk_dot8x),
    .rst         (rst),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .active_in   (active_in),
    .pixel_color4(pixel_color4),
    .half_bright (half_bright),
    .scanline_en (scanline_en),
    .pal_wr_valid(pal_wr_valid),
    .pal_wr_ready(pal_wr_ready),
    .pal_wr_index(pal_wr_index),
    .pal_wr_rgb  (pal_wr_rgb),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active)
  );

  always #5 clk_dot8x = ~clk_dot8x;

  function automatic logic [17:0] boot_color(input int i);
    case (i)
      0:  boot_color = {6'h00, 6'h00, 6'h00};
      1:  boot_color = {6'h3F, 6'h3F, 6'h3F};
      2:  boot_color = {6'h2A, 6'h00, 6'h00};
      3:  boot_color = {6'h00, 6'h2A, 6'h00};
      4:  boot_color = {6'h00, 6'h00, 6'h2A};
      5:  boot_color = {6'h2A, 6'h2A, 6'h00};
      6:  boot_color = {6'h00, 6'h2A, 6'h2A};
      7:  boot_color = {6'h2A, 6'h00, 6'h2A};
      8:  boot_color = {6'h15, 6'h15, 6'h15};
      9:  boot_color = {6'h3F, 6'h15, 6'h15};
      10: boot_color = {6'h15, 6'h3F, 6'h15};
      11: boot_color = {6'h15, 6'h15, 6'h3F};
      12: boot_color = {6'h3F, 6'h3F, 6'h15};
      13: boot_color = {6'h15, 6'h3F, 6'h3F};
      14: boot_color = {6'h3F, 6'h15, 6'h3F};
      default: boot_color = {6'h2A, 6'h2A, 6'h2A};
    endcase
  endfunction

  // Reference state: palette contents, pending writes,
  // and the pixel sampled one edge ago.
  logic [17:0] mpal [16];
  logic [21:0] mq [$];
  logic [17:0] f_rgb;
  logic        f_act;
  logic        f_hs;
  logic        f_vs;
  logic        f_half;
  logic [20:0] exp_out;
  logic        exp_rdy;

  task automatic model_edge();
    logic [17:0] c;
    logic [21:0] head;
    logic        acc;
    if (rst) begin
      for (int i = 0; i < 16; i++) mpal[i] = boot_color(i);
      mq.delete();
      exp_out = {18'h0, 1'b1, 1'b1, 1'b0};
      f_rgb = '0;
      f_act = 1'b0;
      f_hs = 1'b1;
      f_vs = 1'b1;
      f_half = 1'b0;
      exp_rdy = 1'b1;
    end else begin
      c = f_act ? f_rgb : 18'h0;
      if (scanline_en && f_half)
        c = {c[17:12] >> 1, c[11:6] >> 1, c[5:0] >> 1};
      exp_out = {c, f_hs, f_vs, f_act};
      f_rgb = mpal[pixel_color4];
      f_act = active_in;
      f_hs = hsync_in;
      f_vs = vsync_in;
      f_half = half_bright;
      acc = pal_wr_valid && (mq.size() != 4);
      if (mq.size() > 0 && !active_in) begin
        head = mq.pop_front();
        mpal[head[21:18]] = head[17:0];
      end
      if (acc) mq.push_back({pal_wr_index, pal_wr_rgb});
      exp_rdy = (mq.size() != 4);
    end
  endtask

  task automatic check(input string nm,
                       input logic [20:0] got,
                       input logic [20:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_dot8x);
    model_edge();
    #1;
    check("pix", {red, green, blue, hsync, vsync, active},
          exp_out);
    check("rdy", 21'(pal_wr_ready), 21'(exp_rdy));
  endtask

  typedef struct {
    logic        act;
    logic [3:0]  idx;
    logic        scan;
    logic        half;
    logic [17:0] rgb;
  } vec_t;

  vec_t        vt [8];
  logic [7:0]  hpat;
  logic [7:0]  vpat;
  logic [17:0] wv [5];

  initial begin
    vt[0] = '{1'b1, 4'd1, 1'b0, 1'b0, 18'h3FFFF};
    vt[1] = '{1'b1, 4'd1, 1'b1, 1'b1, {6'h1F, 6'h1F, 6'h1F}};
    vt[2] = '{1'b1, 4'd1, 1'b0, 1'b1, 18'h3FFFF};
    vt[3] = '{1'b1, 4'd1, 1'b1, 1'b0, 18'h3FFFF};
    vt[4] = '{1'b0, 4'd1, 1'b0, 1'b0, 18'h00000};
    vt[5] = '{1'b1, 4'd3, 1'b1, 1'b1, {6'h00, 6'h15, 6'h00}};
    vt[6] = '{1'b1, 4'd9, 1'b0, 1'b0, {6'h3F, 6'h15, 6'h15}};
    vt[7] = '{1'b0, 4'd2, 1'b1, 1'b1, 18'h00000};
    hpat = 8'b1011_0010;
    vpat = 8'b0110_1001;
    wv[0] = 18'h12345;
    wv[1] = 18'h0ABCD;
    wv[2] = 18'h3F000;
    wv[3] = 18'h00FC0;
    wv[4] = 18'h11111;

    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    active_in = 1'b0;
    pixel_color4 = 4'd0;
    half_bright = 1'b0;
    scanline_en = 1'b0;
    pal_wr_valid = 1'b0;
    pal_wr_index = 4'd0;
    pal_wr_rgb = 18'd0;
    repeat (3) tick();
    check("reset_out",
          {red, green, blue, hsync, vsync, active, pal_wr_ready},
          {18'h0, 1'b1, 1'b1, 1'b0, 1'b1});

    // Table vectors; the first also checks the 2-cycle
    // latency straight out of reset.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      active_in = vt[i].act;
      pixel_color4 = vt[i].idx;
      scanline_en = vt[i].scan;
      half_bright = vt[i].half;
      tick();
      tick();
      check($sformatf("vec%0d", i),
            21'({red, green, blue, active}),
            21'({vt[i].rgb, vt[i].act}));
    end

    active_in = 1'b0;
    pixel_color4 = 4'd1;
    scanline_en = 1'b0;
    half_bright = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hsync_in = hpat[i];
      vsync_in = vpat[i];
      tick();
      if (i >= 1)
        check("sync_dly", 21'({hsync, vsync, red}),
              21'({hpat[i-1], vpat[i-1], 6'h00}));
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;

    // Fill the queue during visible pixels, then drain it.
    active_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pal_wr_valid = 1'b1;
      pal_wr_index = 4'(4 + i);
      pal_wr_rgb = wv[i];
      check("fill_rdy", 21'(pal_wr_ready), 21'(i < 4));
      tick();
    end
    pal_wr_valid = 1'b0;
    check("full_rdy", 21'(pal_wr_ready), 21'd0);
    active_in = 1'b0;
    tick();
    check("pop_rdy", 21'(pal_wr_ready), 21'd1);
    repeat (3) tick();
    active_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pixel_color4 = 4'(4 + k);
      tick();
      tick();
      check($sformatf("drain%0d", k), 21'({red, green, blue}),
            21'((k < 4) ? wv[k] : boot_color(8)));
    end

    // Last write to an index wins.
    active_in = 1'b0;
    pal_wr_valid = 1'b1;
    pal_wr_index = 4'd3;
    pal_wr_rgb = 18'h00FC0;
    tick();
    pal_wr_rgb = 18'h3F000;
    tick();
    pal_wr_valid = 1'b0;
    repeat (3) tick();
    active_in = 1'b1;
    pixel_color4 = 4'd3;
    tick();
    tick();
    check("last_wins", 21'({red, green, blue}),
          21'({6'h3F, 6'h00, 6'h00}));

    // Reset drops queued writes and reverts the palette.
    pal_wr_valid = 1'b1;
    pal_wr_rgb = 18'h2AAAA;
    tick();
    pal_wr_rgb = 18'h15555;
    tick();
    pal_wr_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_flush",
          {red, green, blue, hsync, vsync, active, pal_wr_ready},
          {18'h0, 1'b1, 1'b1, 1'b0, 1'b1});
    rst = 1'b0;
    active_in = 1'b0;
    repeat (3) tick();
    active_in = 1'b1;
    pixel_color4 = 4'd3;
    tick();
    tick();
    check("rst_pal", 21'({red, green, blue}),
          21'({6'h00, 6'h2A, 6'h00}));

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      active_in = ($urandom_range(0, 3) != 0);
      pixel_color4 = 4'($urandom);
      half_bright = 1'($urandom);
      scanline_en = 1'($urandom);
      pal_wr_valid = 1'($urandom);
      pal_wr_index = 4'($urandom);
      pal_wr_rgb = 18'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
